hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 151 +++++++++++++++
 tb/tb_hazard_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and
// data-memory wait handling with a timeout and a stall-cycle counter.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRd,
  input  logic [4:0]  IFIDRn,
  input  logic [4:0]  IFIDRm,
  input  logic        BranchTaken,
  input  logic        DMemReq,
  input  logic        DMemReady,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        PipeEn,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic        MemErr,
  output logic [15:0] StallCycles
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEMWAIT  = 2'd1;
  localparam logic [1:0] REDIRECT = 2'd2;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [1:0]  state;
  logic [1:0]  stateNext;
  logic        pendRedirect;
  logic [7:0]  waitCnt;
  logic        memErrQ;
  logic [15:0] stallCnt;

  logic        loadUse;
  logic        memTimeout;
  logic        pcWriteInt;
  logic        ifidWriteInt;
  logic        bubbleInt;
  logic        pipeEnInt;
  logic        flushInt;

  // XZR (register 31) is never a real producer, so it cannot create a hazard.
  assign loadUse = IDEXMemRead && (IDEXRd != 5'd31) &&
                   ((IDEXRd == IFIDRn) || (IDEXRd == IFIDRm));

  assign memTimeout = (state == MEMWAIT) && !DMemReady && (waitCnt == TIMEOUT);

  // Next-state and control decode; priority is mem wait, then branch, then load-use.
  always_comb begin
    stateNext    = state;
    pcWriteInt   = 1'b0;
    ifidWriteInt = 1'b0;
    bubbleInt    = 1'b0;
    pipeEnInt    = 1'b0;
    flushInt     = 1'b0;
    case (state)
      RUN: begin
        if (DMemReq && !DMemReady) begin
          stateNext = MEMWAIT;
        end else if (BranchTaken) begin
          pcWriteInt   = 1'b1;
          ifidWriteInt = 1'b1;
          pipeEnInt    = 1'b1;
          flushInt     = 1'b1;
        end else if (loadUse) begin
          bubbleInt = 1'b1;
          pipeEnInt = 1'b1;
        end else begin
          pcWriteInt   = 1'b1;
          ifidWriteInt = 1'b1;
          pipeEnInt    = 1'b1;
        end
      end
      MEMWAIT: begin
        // A branch seen in the completing cycle still counts as pending.
        if (DMemReady || memTimeout)
          stateNext = (pendRedirect || BranchTaken) ? REDIRECT : RUN;
      end
      REDIRECT: begin
        pcWriteInt   = 1'b1;
        ifidWriteInt = 1'b1;
        pipeEnInt    = 1'b1;
        flushInt     = 1'b1;
        stateNext    = RUN;
      end
      default: stateNext = RUN;
    endcase
  end

  // Controls are forced low for as long as reset is held.
  always_comb begin
    PCWrite    = pcWriteInt & rst_n;
    IFIDWrite  = ifidWriteInt & rst_n;
    IDEXBubble = bubbleInt & rst_n;
    PipeEn     = pipeEnInt & rst_n;
    IFIDFlush  = flushInt & rst_n;
    IDEXFlush  = flushInt & rst_n;
    EXMEMFlush = flushInt & rst_n;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= stateNext;
  end

  // Wait counter: loaded with 1 on entering MEMWAIT, cleared on every return to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      waitCnt <= 8'd0;
    else if (state == RUN && stateNext == MEMWAIT)
      waitCnt <= 8'd1;
    else if (state == MEMWAIT && stateNext == MEMWAIT)
      waitCnt <= waitCnt + 8'd1;
    else if (stateNext == RUN)
      waitCnt <= 8'd0;
  end

  // Pending redirect: captured during MEMWAIT, consumed by the REDIRECT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pendRedirect <= 1'b0;
    else if (state == REDIRECT)
      pendRedirect <= 1'b0;
    else if (state == MEMWAIT && BranchTaken)
      pendRedirect <= 1'b1;
  end

  // Sticky memory timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          memErrQ <= 1'b0;
    else if (memTimeout) memErrQ <= 1'b1;
  end

  // Saturating count of cycles with the PC held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stallCnt <= 16'd0;
    else if (!pcWriteInt && stallCnt != 16'hFFFF)
      stallCnt <= stallCnt + 16'd1;
  end

  assign MemErr      = memErrQ;
  assign StallCycles = stallCnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller: vector table for the RUN-state
// decode plus hand-written sequences for waits, redirects, timeout and reset.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IDEXMemRead;
  logic [4:0]  IDEXRd;
  logic [4:0]  IFIDRn;
  logic [4:0]  IFIDRm;
  logic        BranchTaken;
  logic        DMemReq;
  logic        DMemReady;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        PipeEn;
  logic        IFIDFlush;
  logic        IDEXFlush;
  logic        EXMEMFlush;
  logic        MemErr;
  logic [15:0] StallCycles;

  int total = 0;
  int bad   = 0;

  // {PCWrite, IFIDWrite, IDEXBubble, PipeEn, IFIDFlush, IDEXFlush, EXMEMFlush}
  localparam logic [6:0] O_NORM   = 7'b1101000;
  localparam logic [6:0] O_BUBBLE = 7'b0011000;
  localparam logic [6:0] O_FLUSH  = 7'b1101111;
  localparam logic [6:0] O_FROZEN = 7'b0000000;

  logic [6:0] outs;
  assign outs = {PCWrite, IFIDWrite, IDEXBubble, PipeEn, IFIDFlush, IDEXFlush, EXMEMFlush};

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  hazard_controller #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .IDEXMemRead(IDEXMemRead), .IDEXRd(IDEXRd), .IFIDRn(IFIDRn), .IFIDRm(IFIDRm),
    .BranchTaken(BranchTaken), .DMemReq(DMemReq), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble), .PipeEn(PipeEn),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
    .MemErr(MemErr), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic setIn(input logic mr, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic br, input logic req, input logic rdy);
    IDEXMemRead = mr; IDEXRd = rd; IFIDRn = rn; IFIDRm = rm;
    BranchTaken = br; DMemReq = req; DMemReady = rdy;
  endtask

  // Move to the next negedge (one rising edge passes), then settle.
  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic resetDut();
    @(negedge clk);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    vecs[0] = '{"idle",          1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[1] = '{"lu_rn",         1'b1, 5'd5,  5'd5,  5'd7, 1'b0, 1'b0, 1'b0, O_BUBBLE};
    vecs[2] = '{"lu_rm",         1'b1, 5'd5,  5'd3,  5'd5, 1'b0, 1'b0, 1'b0, O_BUBBLE};
    vecs[3] = '{"xzr",           1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[4] = '{"no_match",      1'b1, 5'd5,  5'd6,  5'd7, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[5] = '{"match_no_load", 1'b0, 5'd5,  5'd5,  5'd5, 1'b0, 1'b0, 1'b0, O_NORM};
    vecs[6] = '{"br_and_lu",     1'b1, 5'd9,  5'd9,  5'd1, 1'b1, 1'b0, 1'b0, O_FLUSH};
    vecs[7] = '{"br_only",       1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b0, 1'b0, O_FLUSH};
    vecs[8] = '{"req_rdy_lu",    1'b1, 5'd2,  5'd4,  5'd2, 1'b0, 1'b1, 1'b1, O_BUBBLE};
    vecs[9] = '{"req_rdy_br",    1'b0, 5'd0,  5'd0,  5'd0, 1'b1, 1'b1, 1'b1, O_FLUSH};

    rst_n = 1'b0;
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("reset_outs", 32'(outs), 32'(O_FROZEN));
    check("reset_stall", 32'(StallCycles), 32'd0);
    check("reset_memerr", 32'(MemErr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RUN-state decode table; three rows stall the PC.
    for (int i = 0; i < 10; i++) begin
      setIn(vecs[i].mr, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].br, vecs[i].req, vecs[i].rdy);
      #1;
      check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      @(negedge clk);
    end
    #1;
    check("table_stall", 32'(StallCycles), 32'd3);

    // Load-use for one cycle then cleared: exactly one bubble.
    resetDut();
    setIn(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_seq_bubble", 32'(outs), 32'(O_BUBBLE));
    @(negedge clk);
    setIn(1'b0, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
    #1;
    check("lu_seq_after", 32'(outs), 32'(O_NORM));
    nextCycle();
    check("lu_seq_stall", 32'(StallCycles), 32'd1);

    // Mem wait without branch returns straight to RUN, no flush.
    resetDut();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("mw_enter", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    DMemReady = 1'b1;
    #1;
    check("mw_done_frozen", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("mw_back_run", 32'(outs), 32'(O_NORM));
    check("mw_stall", 32'(StallCycles), 32'd2);

    // Mem wait with a branch in wait cycle 2: 5 frozen cycles then REDIRECT.
    resetDut();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("mwb_c1", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    setIn(1'b1, 5'd6, 5'd6, 5'd6, 1'b0, 1'b1, 1'b0);
    #1;
    check("mwb_c2_ignore_lu", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    BranchTaken = 1'b1;
    #1;
    check("mwb_c3_branch", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    BranchTaken = 1'b0;
    #1;
    check("mwb_c4", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    DMemReady = 1'b1;
    #1;
    check("mwb_c5_ready", 32'(outs), 32'(O_FROZEN));
    @(negedge clk);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("mwb_redirect", 32'(outs), 32'(O_FLUSH));
    check("mwb_stall", 32'(StallCycles), 32'd5);
    nextCycle();
    check("mwb_run", 32'(outs), 32'(O_NORM));

    // Timeout with MEM_TIMEOUT=4: five frozen cycles, then sticky MemErr.
    resetDut();
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      #1;
      check($sformatf("to_frozen_c%0d", c), 32'(outs), 32'(O_FROZEN));
      check($sformatf("to_noerr_c%0d", c), 32'(MemErr), 32'd0);
      @(negedge clk);
    end
    DMemReq = 1'b0;
    #1;
    check("to_memerr", 32'(MemErr), 32'd1);
    check("to_run", 32'(outs), 32'(O_NORM));
    check("to_stall", 32'(StallCycles), 32'd5);
    nextCycle();
    nextCycle();
    check("to_sticky", 32'(MemErr), 32'd1);

    // Reset asserted mid-wait with a pending redirect.
    resetDut();
    check("rst_clears_err", 32'(MemErr), 32'd0);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    BranchTaken = 1'b1;
    @(negedge clk);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmw_outs", 32'(outs), 32'(O_FROZEN));
    check("rmw_stall", 32'(StallCycles), 32'd0);
    check("rmw_memerr", 32'(MemErr), 32'd0);
    @(negedge clk);
    setIn(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rmw_release", 32'(outs), 32'(O_NORM));
    nextCycle();
    check("rmw_no_redirect", 32'(outs), 32'(O_NORM));
    check("rmw_no_err", 32'(MemErr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
